// File: rtl/sysid_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sysid_check_ctrl
// Description : Verifies the sysid slave's ID and timestamp words at boot
//               and on demand, retries on mismatch, and reports the result
//               through status pins, an interrupt and an Avalon-MM slave.
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_check_ctrl #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1459509197,
   parameter int unsigned SETTLE_CYCLES      = 2,
   parameter int unsigned RETRY_MAX          = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        sysid_address,
   input  logic [31:0] sysid_readdata,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        busy,
   output logic        done,
   output logic        sysid_ok,
   output logic        irq
);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_ID_PHASE = 3'd1;
   localparam logic [2:0] c_TS_PHASE = 3'd2;
   localparam logic [2:0] c_EVAL     = 3'd3;
   localparam logic [2:0] c_DONE     = 3'd4;

   localparam logic [3:0] c_SETTLE    = 4'(SETTLE_CYCLES);
   localparam logic [3:0] c_RETRY_MAX = 4'(RETRY_MAX);

   logic [2:0]  r_state;
   logic [3:0]  r_settle;
   logic [3:0]  r_attempts;
   logic [31:0] r_cap_id;
   logic [31:0] r_cap_ts;
   logic        r_done;
   logic        r_ok;
   logic        r_irq_en;
   logic        r_auto_start;
   logic [31:0] r_readdata;

   logic        w_busy;
   logic        w_idle_or_done;
   logic        w_start;
   logic        w_clr_done;
   logic        w_last;
   logic        w_match;
   logic        w_finish;
   logic [31:0] w_rd_word;
   logic        w_unused;

   assign w_busy         = (r_state == c_ID_PHASE) || (r_state == c_TS_PHASE) ||
                           (r_state == c_EVAL);
   assign w_idle_or_done = (r_state == c_IDLE) || (r_state == c_DONE);
   // Auto-start is only pending for the first cycle after reset release.
   assign w_start        = w_idle_or_done &&
                           (r_auto_start || (write && (address == 2'd1) && writedata[0]));
   assign w_clr_done     = write && (address == 2'd0) && writedata[1];
   assign w_last         = (r_settle == c_SETTLE);
   assign w_match        = (r_cap_id == EXPECTED_ID) && (r_cap_ts == EXPECTED_TIMESTAMP);
   assign w_finish       = (r_state == c_EVAL) && (w_match || (r_attempts >= c_RETRY_MAX));
   assign w_unused       = &{1'b0, writedata[31:2]};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= c_IDLE;
         r_settle     <= 4'd0;
         r_attempts   <= 4'd0;
         r_cap_id     <= 32'd0;
         r_cap_ts     <= 32'd0;
         r_ok         <= 1'b0;
         r_auto_start <= 1'b1;
      end else begin
         r_auto_start <= 1'b0;
         case (r_state)
            c_IDLE, c_DONE: begin
               if (w_start) begin
                  r_state    <= c_ID_PHASE;
                  r_settle   <= 4'd0;
                  r_attempts <= 4'd1;
                  r_ok       <= 1'b0;
               end
            end
            c_ID_PHASE: begin
               if (w_last) begin
                  r_cap_id <= sysid_readdata;
                  r_settle <= 4'd0;
                  r_state  <= c_TS_PHASE;
               end else begin
                  r_settle <= r_settle + 4'd1;
               end
            end
            c_TS_PHASE: begin
               if (w_last) begin
                  r_cap_ts <= sysid_readdata;
                  r_settle <= 4'd0;
                  r_state  <= c_EVAL;
               end else begin
                  r_settle <= r_settle + 4'd1;
               end
            end
            c_EVAL: begin
               if (w_finish) begin
                  r_ok    <= w_match;
                  r_state <= c_DONE;
               end else begin
                  r_attempts <= r_attempts + 4'd1;
                  r_state    <= c_ID_PHASE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // Entering DONE takes priority over a software clear in the same cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_done <= 1'b0;
      end else if (w_finish) begin
         r_done <= 1'b1;
      end else if (w_start || w_clr_done) begin
         r_done <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_en <= 1'b0;
      end else if (write && (address == 2'd1) && writedata[1]) begin
         r_irq_en <= 1'b1;
      end
   end

   always_comb begin
      w_rd_word = 32'd0;
      case (address)
         2'd0:    w_rd_word = {24'd0, r_attempts, 1'b0, r_ok, r_done, w_busy};
         2'd1:    w_rd_word = {30'd0, r_irq_en, 1'b0};
         2'd2:    w_rd_word = r_cap_id;
         default: w_rd_word = r_cap_ts;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= 32'd0;
      end else if (read) begin
         r_readdata <= w_rd_word;
      end
   end

   assign sysid_address = (r_state == c_TS_PHASE);
   assign readdata      = r_readdata;
   assign busy          = w_busy;
   assign done          = r_done;
   assign sysid_ok      = r_ok;
   assign irq           = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_sysid_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysid_check_ctrl
// Description : Directed, table-driven self-checking bench for sysid_check_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_check_ctrl;

   localparam logic [31:0] c_ID = 32'd0;
   localparam logic [31:0] c_TS = 32'd1459509197;

   logic        clock;
   logic        reset_n;
   logic        sysid_address;
   logic [31:0] sysid_readdata;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        busy;
   logic        done;
   logic        sysid_ok;
   logic        irq;

   int          errors = 0;
   int          checks = 0;
   bit          ts_force_bad = 1'b0;
   int          ts_bad_count = 0;

   sysid_check_ctrl dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .sysid_address  (sysid_address),
      .sysid_readdata (sysid_readdata),
      .address        (address),
      .read           (read),
      .write          (write),
      .writedata      (writedata),
      .readdata       (readdata),
      .busy           (busy),
      .done           (done),
      .sysid_ok       (sysid_ok),
      .irq            (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // sysid slave model; word 1 can be corrupted permanently or for N TS phases
   assign sysid_readdata = sysid_address ?
                           ((ts_force_bad || (ts_bad_count > 0)) ? 32'd0 : c_TS) : c_ID;

   always @(negedge sysid_address) begin
      if (ts_bad_count > 0) ts_bad_count = ts_bad_count - 1;
   end

   typedef struct {
      logic exp_addr;
      logic exp_busy;
      logic exp_done;
      logic exp_ok;
   } tl_t;

   typedef struct {
      bit          is_wr;
      logic [1:0]  addr;
      logic [31:0] data;
   } rv_t;

   tl_t tl[9];
   rv_t rv[8];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      tick();
      write     = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      read    = 1'b1;
      tick();
      read    = 1'b0;
      d       = readdata;
   endtask

   logic [31:0] rdv;

   initial begin
      // boot timeline: cycle 0 is IDLE, 1..3 ID, 4..6 TS, 7 EVAL, 8 DONE
      tl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tl[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tl[3] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tl[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      tl[5] = '{1'b1, 1'b1, 1'b0, 1'b0};
      tl[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
      tl[7] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tl[8] = '{1'b0, 1'b0, 1'b1, 1'b1};

      rv[0] = '{1'b0, 2'd0, 32'h16};
      rv[1] = '{1'b0, 2'd1, 32'h0};
      rv[2] = '{1'b0, 2'd2, c_ID};
      rv[3] = '{1'b0, 2'd3, c_TS};
      rv[4] = '{1'b1, 2'd2, 32'hDEADBEEF};
      rv[5] = '{1'b0, 2'd2, c_ID};
      rv[6] = '{1'b1, 2'd3, 32'h12345678};
      rv[7] = '{1'b0, 2'd3, c_TS};

      reset_n   = 1'b0;
      address   = 2'd0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = 32'd0;
      repeat (2) tick();

      check("rst_saddr", {31'd0, sysid_address}, 32'd0);
      check("rst_rdata", readdata, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ok", {31'd0, sysid_ok}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);

      // ---- boot auto-check
      reset_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("boot_c%0d_saddr", i), {31'd0, sysid_address}, {31'd0, tl[i].exp_addr});
         check($sformatf("boot_c%0d_busy", i), {31'd0, busy}, {31'd0, tl[i].exp_busy});
         check($sformatf("boot_c%0d_done", i), {31'd0, done}, {31'd0, tl[i].exp_done});
         check($sformatf("boot_c%0d_ok", i), {31'd0, sysid_ok}, {31'd0, tl[i].exp_ok});
         if (i < 8) tick();
      end

      // ---- register map, including writes to read-only words
      for (int i = 0; i < 8; i++) begin
         if (rv[i].is_wr) begin
            bus_wr(rv[i].addr, rv[i].data);
         end else begin
            bus_rd(rv[i].addr, rdv);
            check($sformatf("reg_v%0d_a%0d", i, rv[i].addr), rdv, rv[i].data);
         end
      end

      // ---- irq enable, irq with done, clear via STATUS
      check("irq_before_en", {31'd0, irq}, 32'd0);
      bus_wr(2'd1, 32'h2);
      check("irq_after_en", {31'd0, irq}, 32'd1);
      bus_wr(2'd1, 32'h1);
      check("irq_start_drop", {31'd0, irq}, 32'd0);
      repeat (6) tick();
      check("irq_t7", {31'd0, irq}, 32'd0);
      tick();
      check("irq_t8", {31'd0, irq}, 32'd1);
      bus_rd(2'd1, rdv);
      check("ctrl_irq_en", rdv, 32'h2);
      bus_wr(2'd0, 32'h2);
      check("clr_irq", {31'd0, irq}, 32'd0);
      check("clr_done", {31'd0, done}, 32'd0);
      bus_rd(2'd0, rdv);
      check("status_after_clr", rdv, 32'h14);

      // ---- word 1 permanently wrong: three attempts of 7 cycles each
      ts_force_bad = 1'b1;
      bus_wr(2'd1, 32'h1);
      check("perm_ok_cleared", {31'd0, sysid_ok}, 32'd0);
      repeat (9) tick();
      check("perm_t10_saddr", {31'd0, sysid_address}, 32'd0);
      tick();
      check("perm_t11_saddr", {31'd0, sysid_address}, 32'd1);
      repeat (10) tick();
      check("perm_t21_busy", {31'd0, busy}, 32'd1);
      check("perm_t21_done", {31'd0, done}, 32'd0);
      tick();
      check("perm_t22_done", {31'd0, done}, 32'd1);
      check("perm_t22_ok", {31'd0, sysid_ok}, 32'd0);
      check("perm_t22_irq", {31'd0, irq}, 32'd1);
      bus_rd(2'd0, rdv);
      check("perm_status", rdv, 32'h32);
      bus_rd(2'd3, rdv);
      check("perm_cap_ts", rdv, 32'd0);
      ts_force_bad = 1'b0;

      // ---- word 1 wrong on first attempt only
      ts_bad_count = 1;
      bus_wr(2'd1, 32'h1);
      repeat (13) tick();
      check("once_t14_done", {31'd0, done}, 32'd0);
      tick();
      check("once_t15_done", {31'd0, done}, 32'd1);
      check("once_t15_ok", {31'd0, sysid_ok}, 32'd1);
      bus_rd(2'd0, rdv);
      check("once_status", rdv, 32'h26);

      // ---- start while busy is ignored
      bus_wr(2'd1, 32'h1);
      repeat (2) tick();
      bus_wr(2'd1, 32'h1);
      repeat (3) tick();
      check("busy_start_t7", {31'd0, done}, 32'd0);
      tick();
      check("busy_start_t8", {31'd0, done}, 32'd1);
      bus_rd(2'd0, rdv);
      check("busy_start_status", rdv, 32'h16);

      // ---- done clear collides with entry to DONE: set wins
      bus_wr(2'd1, 32'h1);
      repeat (6) tick();
      bus_wr(2'd0, 32'h2);
      check("collide_done", {31'd0, done}, 32'd1);

      // ---- async reset during TS_PHASE, then fresh auto-check
      bus_rd(2'd0, rdv);
      bus_wr(2'd1, 32'h1);
      repeat (3) tick();
      check("midrst_in_ts", {31'd0, sysid_address}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_saddr", {31'd0, sysid_address}, 32'd0);
      check("midrst_rdata", readdata, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_irq", {31'd0, irq}, 32'd0);
      tick();
      reset_n = 1'b1;
      repeat (7) tick();
      check("post_rst_t7_done", {31'd0, done}, 32'd0);
      tick();
      check("post_rst_t8_done", {31'd0, done}, 32'd1);
      check("post_rst_t8_ok", {31'd0, sysid_ok}, 32'd1);
      bus_rd(2'd1, rdv);
      check("post_rst_irq_en", rdv, 32'h0);
      bus_rd(2'd0, rdv);
      check("post_rst_status", rdv, 32'h16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
